gray_to_binary_pipe: RTL

//  Streaming Gray-to-binary decoder; inverse of the team's binary-to-Gray encoder.

---
 rtl/gray_to_binary_pipe_pkg.sv | 14 +
 rtl/gray2bin_comb.sv | 19 +
 rtl/gray_to_binary_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/gray_to_binary_pipe_pkg.sv
// Shared constants and helpers for the Gray-to-binary decode pipeline.
// The optional step checker in the top is enabled with GRAY_STEP_CHECK_EN.
package gray_to_binary_pipe_pkg;

    localparam int GRAY_DEFAULT_W         = 4;
    localparam int GRAY_DEFAULT_ERR_CNT_W = 8;
    localparam int GRAY_MAX_W             = 32;

    // True when exactly one bit differs between two consecutive Gray words.
    function automatic logic is_single_bit_step(input logic [GRAY_MAX_W-1:0] diff);
        return (diff != '0) && ((diff & (diff - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder (prefix XOR, MSB down).
module gray2bin_comb
    import gray_to_binary_pipe_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin            = '0;
        bin[WIDTH-1]   = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_to_binary_pipe.sv
// Two-stage streaming Gray-to-binary decoder with valid/ready backpressure.
// Define GRAY_STEP_CHECK_EN to add single-bit-step checking and a saturating error counter.
module gray_to_binary_pipe
    import gray_to_binary_pipe_pkg::*;
#(
    parameter int WIDTH     = GRAY_DEFAULT_W,
    parameter int ERR_CNT_W = GRAY_DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic             vld_p1;
    logic             vld_p2;
    logic [WIDTH-1:0] gray_p1;
    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] bin_p2;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    // Stage 1: capture the Gray word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            gray_p1 <= gray_in;
        end
    end

    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (gray_p1),
        .bin  (bin_dec)
    );

    // Stage 2: register the decoded word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            bin_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                bin_p2 <= bin_dec;
            end
        end
    end

    assign out_valid = vld_p2;
    assign bin_out   = bin_p2;

`ifdef GRAY_STEP_CHECK_EN
    logic                 out_fire;
    logic                 have_prev;
    logic [WIDTH-1:0]     prev_gray;
    logic                 step_bad;
    logic                 step_err_p1;
    logic                 step_err_p2;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign out_fire = vld_p2 && out_ready;
    // A repeated word has zero distance and is flagged like any multi-bit jump.
    assign step_bad = have_prev && !is_single_bit_step(GRAY_MAX_W'(gray_in ^ prev_gray));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev   <= 1'b0;
            prev_gray   <= '0;
            step_err_p1 <= 1'b0;
            step_err_p2 <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (in_fire) begin
                have_prev <= 1'b1;
                prev_gray <= gray_in;
            end
            if (s1_adv) begin
                step_err_p1 <= in_fire && step_bad;
            end
            if (s2_adv && vld_p1) begin
                step_err_p2 <= step_err_p1;
            end
            if (out_fire && step_err_p2 && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign step_err = step_err_p2;
    assign err_cnt  = err_cnt_q;
`else
    assign step_err = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule
